// File: rtl/fp8_pkg.sv
// Shared FP8 format constants and the per-element format selector.
package fp8_pkg;

  typedef enum logic {
    FMT_E4M3 = 1'b0,
    FMT_E5M2 = 1'b1
  } fp8_fmt_e;

  localparam int FP16_BIAS = 15;
  localparam int E4M3_BIAS = 7;
  localparam int E5M2_BIAS = 15;

  // Magnitude bytes (sign excluded)
  localparam logic [6:0] E4M3_MAX = 7'h7E;
  localparam logic [6:0] E5M2_MAX = 7'h7B;
  localparam logic [6:0] E4M3_NAN = 7'h7F;
  localparam logic [6:0] E5M2_NAN = 7'h7E;

endpackage

// File: rtl/fp16_to_fp8_round.sv
// FP16 -> FP8 (E4M3/E5M2) converter: RNE, saturating overflow, flush-to-zero.
// Purely combinational; sat flags an overflowing or infinite input.
module fp16_to_fp8_round
  import fp8_pkg::*;
(
  input  logic [15:0] fp16,
  input  fp8_fmt_e    fmt,
  output logic [7:0]  fp8,
  output logic        sat
);

  localparam logic [5:0] E4M3_EOFF = 6'(FP16_BIAS - E4M3_BIAS);
  localparam logic [5:0] E5M2_EOFF = 6'(FP16_BIAS - E5M2_BIAS);

  logic       sgn;
  logic [4:0] e16;
  logic [9:0] man;
  logic       is_e5;
  logic [5:0] eoff;
  logic [5:0] e8;
  logic [5:0] e8r;
  logic       uflow;
  logic       rnd4;
  logic       rnd5;
  logic [3:0] sum4;
  logic [2:0] sum5;
  logic       carry;
  logic       ovf;
  logic [6:0] max_fin;
  logic [6:0] nan_code;

  assign sgn   = fp16[15];
  assign e16   = fp16[14:10];
  assign man   = fp16[9:0];
  assign is_e5 = (fmt == FMT_E5M2);
  assign eoff  = is_e5 ? E5M2_EOFF : E4M3_EOFF;

  // Zero/subnormal inputs also land here, since their exponent is 0
  assign uflow = ({1'b0, e16} <= eoff);
  assign e8    = {1'b0, e16} - eoff;

  assign rnd4  = man[6] & (man[7] | (|man[5:0]));
  assign rnd5  = man[7] & (man[8] | (|man[6:0]));
  assign sum4  = {1'b0, man[9:7]} + {3'b000, rnd4};
  assign sum5  = {1'b0, man[9:8]} + {2'b00, rnd5};
  assign carry = is_e5 ? sum5[2] : sum4[3];
  assign e8r   = e8 + {5'b00000, carry};

  // E4M3 reserves exponent 15 with mantissa 111 for NaN
  assign ovf = is_e5 ? (e8r >= 6'd31)
                     : ((e8r > 6'd15) || ((e8r == 6'd15) && (sum4[2:0] == 3'b111)));

  assign max_fin  = is_e5 ? E5M2_MAX : E4M3_MAX;
  assign nan_code = is_e5 ? E5M2_NAN : E4M3_NAN;

  always_comb begin
    fp8 = {sgn, 7'h00};
    sat = 1'b0;
    if (e16 == 5'h1F) begin
      if (|man) begin
        fp8 = {sgn, nan_code};
      end else begin
        fp8 = {sgn, max_fin};
        sat = 1'b1;
      end
    end else if (uflow) begin
      fp8 = {sgn, 7'h00};
    end else if (ovf) begin
      fp8 = {sgn, max_fin};
      sat = 1'b1;
    end else if (is_e5) begin
      fp8 = {sgn, e8r[4:0], sum5[1:0]};
    end else begin
      fp8 = {sgn, e8r[3:0], sum4[2:0]};
    end
  end

endmodule

// File: rtl/fp16_to_fp8_packer.sv
// Streams FP16 elements to FP8 and packs four lanes per 32-bit word; 2-cycle latency.
// S2 keeps filling free lanes under backpressure; only a completing element stalls S1.
module fp16_to_fp8_packer
  import fp8_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             e5m2mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [3:0]       out_keep,
  output logic [CNT_W-1:0] sat_cnt
);

  fp8_fmt_e    fmt;
  logic [7:0]  cvt_byte;
  logic        cvt_sat;

  logic        s1_full;
  logic [7:0]  s1_byte;
  logic        s1_last;

  logic [1:0]  lane;
  logic [31:0] acc_data;
  logic [3:0]  acc_keep;

  logic        in_fire;
  logic        s1_done;
  logic        out_free;
  logic        s1_drain;
  logic [31:0] lane_data;
  logic [3:0]  lane_keep;

  assign fmt = e5m2mode ? FMT_E5M2 : FMT_E4M3;

  fp16_to_fp8_round u_round (
    .fp16 (in_data),
    .fmt  (fmt),
    .fp8  (cvt_byte),
    .sat  (cvt_sat)
  );

  assign s1_done   = s1_last || (lane == 2'd3);
  assign out_free  = !out_valid || out_ready;
  assign s1_drain  = s1_full && (!s1_done || out_free);
  assign in_ready  = !s1_full || s1_drain;
  assign in_fire   = in_valid && in_ready;
  assign lane_data = {24'h000000, s1_byte} << {lane, 3'b000};
  assign lane_keep = 4'b0001 << lane;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_full <= 1'b0;
      s1_byte <= 8'h00;
      s1_last <= 1'b0;
      sat_cnt <= '0;
    end else begin
      if (in_fire) begin
        s1_full <= 1'b1;
        s1_byte <= cvt_byte;
        s1_last <= in_last;
      end else if (s1_drain) begin
        s1_full <= 1'b0;
      end
      if (in_fire && cvt_sat && (sat_cnt != {CNT_W{1'b1}})) begin
        sat_cnt <= sat_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane      <= 2'd0;
      acc_data  <= 32'h0;
      acc_keep  <= 4'h0;
      out_valid <= 1'b0;
      out_data  <= 32'h0;
      out_keep  <= 4'h0;
    end else if (s1_drain && s1_done) begin
      out_valid <= 1'b1;
      out_data  <= acc_data | lane_data;
      out_keep  <= acc_keep | lane_keep;
      acc_data  <= 32'h0;
      acc_keep  <= 4'h0;
      lane      <= 2'd0;
    end else begin
      if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (s1_drain) begin
        acc_data <= acc_data | lane_data;
        acc_keep <= acc_keep | lane_keep;
        lane     <= lane + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_fp16_to_fp8_packer.sv
// Bench for fp16_to_fp8_packer: directed vector table, hand sequences and a randomized scoreboard run.
module tb_fp16_to_fp8_packer;

  logic        clk;
  logic        rst_n;
  logic        e5m2mode;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic [15:0] sat_cnt;

  fp16_to_fp8_packer #(.CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .e5m2mode  (e5m2mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_keep  (out_keep),
    .sat_cnt   (sat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
  } word_t;

  typedef struct {
    logic [15:0] din;
    bit          e5;
    logic [7:0]  dout;
    bit          sat;
  } vec_t;

  int          tests = 0;
  int          fails = 0;
  word_t       exp_q[$];
  logic [31:0] cur_d = 32'h0;
  logic [3:0]  cur_k = 4'h0;
  int          cur_lane = 0;
  int          sat_exp = 0;
  int          bp_mode = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic real pow2(input int n);
    real r = 1.0;
    if (n >= 0) repeat (n) r = r * 2.0;
    else repeat (-n) r = r / 2.0;
    return r;
  endfunction

  function automatic real fp8_val(input int code, input bit e5);
    int mb   = e5 ? 2 : 3;
    int bias = e5 ? 15 : 7;
    int ef   = code >> mb;
    int mf   = code & ((1 << mb) - 1);
    return (1.0 + real'(mf) / real'(1 << mb)) * pow2(ef - bias);
  endfunction

  // Nearest representable normal by exhaustive search; the code just past max finite stands for overflow
  function automatic void ref_conv(input logic [15:0] x, input bit e5,
                                   output logic [7:0] y, output bit sat);
    int  e16  = int'(x[14:10]);
    int  m    = int'(x[9:0]);
    bit  s    = x[15];
    int  maxc = e5 ? 'h7B : 'h7E;
    int  minc = e5 ? 4 : 8;
    int  best;
    real v, d, best_d;
    sat = 1'b0;
    y   = {s, 7'h00};
    if (e16 == 31) begin
      if (m != 0) y = {s, (e5 ? 7'h7E : 7'h7F)};
      else begin
        y   = {s, 7'(maxc)};
        sat = 1'b1;
      end
      return;
    end
    if (e16 == 0) return;
    v = (1.0 + real'(m) / 1024.0) * pow2(e16 - 15);
    if (v < fp8_val(minc, e5)) return;
    best   = minc;
    best_d = v - fp8_val(minc, e5);
    if (best_d < 0.0) best_d = -best_d;
    for (int c = minc + 1; c <= maxc + 1; c++) begin
      d = v - fp8_val(c, e5);
      if (d < 0.0) d = -d;
      if ((d < best_d) || ((d == best_d) && (c % 2 == 0))) begin
        best   = c;
        best_d = d;
      end
    end
    if (best == maxc + 1) begin
      sat  = 1'b1;
      best = maxc;
    end
    y = {s, 7'(best)};
  endfunction

  // Called at posedge+1; returns at posedge+1 right after the accepting edge
  task automatic send(input logic [15:0] d, input bit e5, input bit last,
                      input logic [7:0] expb, input bit expsat);
    bit ok = 1'b0;
    int n  = 0;
    in_valid = 1'b1;
    in_data  = d;
    e5m2mode = e5;
    in_last  = last;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: in_ready stuck low for element %h", d);
      return;
    end
    cur_d = cur_d | ({24'h0, expb} << (8 * cur_lane));
    cur_k = cur_k | (4'b0001 << cur_lane);
    if (expsat) sat_exp++;
    if (last || cur_lane == 3) begin
      exp_q.push_back('{d: cur_d, k: cur_k});
      cur_d    = 32'h0;
      cur_k    = 4'h0;
      cur_lane = 0;
    end else begin
      cur_lane++;
    end
  endtask

  task automatic send_rand(input bit last);
    logic [15:0] d;
    logic [7:0]  y;
    bit          e5, st;
    d  = 16'($urandom);
    e5 = 1'($urandom);
    if ($urandom % 4 == 0) d[7:0] = ($urandom % 2 == 1) ? 8'h80 : {d[7], 7'h40};
    ref_conv(d, e5, y, st);
    send(d, e5, last, y, st);
  endtask

  task automatic drain;
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_pending_words", 64'(exp_q.size()), 64'd0);
  endtask

  always @(posedge clk) begin
    #2;
    case (bp_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'b0;
      default: out_ready = ($urandom % 4 != 0);
    endcase
  end

  bit          hold = 1'b0;
  logic [31:0] held_d;
  logic [3:0]  held_k;
  word_t       got;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_data", 64'(out_data), 64'(held_d));
        check("hold_keep", 64'(out_keep), 64'(held_k));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL extra_word: got %h keep %h expected none", out_data, out_keep);
        end else begin
          got = exp_q.pop_front();
          check("word_data", 64'(out_data), 64'(got.d));
          check("word_keep", 64'(out_keep), 64'(got.k));
        end
      end
      hold   = out_valid && !out_ready;
      held_d = out_data;
      held_k = out_keep;
    end
  end

  vec_t tbl[14];
  bit   saw_stall;

  initial begin
    tbl[0]  = '{16'h3C40, 1'b0, 8'h38, 1'b0};
    tbl[1]  = '{16'h3CC0, 1'b0, 8'h3A, 1'b0};
    tbl[2]  = '{16'h5F40, 1'b0, 8'h7E, 1'b0};
    tbl[3]  = '{16'h5F80, 1'b0, 8'h7E, 1'b1};
    tbl[4]  = '{16'hE3D0, 1'b0, 8'hFE, 1'b1};
    tbl[5]  = '{16'h7C00, 1'b0, 8'h7E, 1'b1};
    tbl[6]  = '{16'h7E00, 1'b0, 8'h7F, 1'b0};
    tbl[7]  = '{16'h7BFF, 1'b1, 8'h7B, 1'b1};
    tbl[8]  = '{16'h3C00, 1'b1, 8'h3C, 1'b0};
    tbl[9]  = '{16'h2400, 1'b0, 8'h08, 1'b0};
    tbl[10] = '{16'h1C00, 1'b0, 8'h00, 1'b0};
    tbl[11] = '{16'h83FF, 1'b0, 8'h80, 1'b0};
    tbl[12] = '{16'h7E00, 1'b1, 8'h7E, 1'b0};
    tbl[13] = '{16'hFC00, 1'b1, 8'hFB, 1'b1};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 16'h0;
    in_last   = 1'b0;
    e5m2mode  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_keep", 64'(out_keep), 64'd0);
    check("rst_sat_cnt", 64'(sat_cnt), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Full E4M3 word and its two-cycle latency
    send(16'h3C00, 1'b0, 1'b0, 8'h38, 1'b0);
    send(16'h4000, 1'b0, 1'b0, 8'h40, 1'b0);
    send(16'h4200, 1'b0, 1'b0, 8'h44, 1'b0);
    send(16'h4400, 1'b0, 1'b1, 8'h48, 1'b0);
    @(negedge clk);
    check("lat_cycle1_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("lat_cycle2_valid", 64'(out_valid), 64'd1);
    check("lat_word_data", 64'(out_data), 64'h48444038);
    @(posedge clk);
    #1;
    drain();

    foreach (tbl[i]) begin
      send(tbl[i].din, tbl[i].e5, 1'b1, tbl[i].dout, tbl[i].sat);
      check($sformatf("vec%0d_sat_cnt", i), 64'(sat_cnt), 64'(sat_exp));
    end
    drain();

    // Partial flush, then the next burst must restart at lane 0
    send(16'h3C00, 1'b0, 1'b0, 8'h38, 1'b0);
    send(16'h4000, 1'b0, 1'b1, 8'h40, 1'b0);
    send(16'h4400, 1'b0, 1'b1, 8'h48, 1'b0);
    drain();

    // Output stalled for ten cycles while streaming
    saw_stall = 1'b0;
    bp_mode   = 1;
    @(posedge clk);
    #1;
    fork
      begin
        for (int i = 0; i < 12; i++) send_rand(i % 4 == 3);
      end
      begin
        repeat (10) @(posedge clk);
        bp_mode = 0;
      end
      begin
        repeat (12) begin
          @(negedge clk);
          if (!in_ready) saw_stall = 1'b1;
        end
      end
    join
    check("bp_in_ready_dropped", 64'(saw_stall), 64'd1);
    drain();

    // Reset in the middle of a word discards it
    send(16'h4000, 1'b0, 1'b0, 8'h40, 1'b0);
    send(16'h4200, 1'b0, 1'b0, 8'h44, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_out_data", 64'(out_data), 64'd0);
    check("midrst_out_keep", 64'(out_keep), 64'd0);
    check("midrst_sat_cnt", 64'(sat_cnt), 64'd0);
    cur_d    = 32'h0;
    cur_k    = 4'h0;
    cur_lane = 0;
    sat_exp  = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    check("postrst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    send(16'h3C00, 1'b1, 1'b0, 8'h3C, 1'b0);
    send(16'h3C00, 1'b0, 1'b0, 8'h38, 1'b0);
    send(16'h4000, 1'b1, 1'b0, 8'h40, 1'b0);
    send(16'h4400, 1'b0, 1'b1, 8'h48, 1'b0);
    drain();

    // Random mix of formats, bursts, gaps and sink stalls
    bp_mode = 2;
    for (int i = 0; i < 300; i++) begin
      if ($urandom % 5 == 0) begin
        @(posedge clk);
        #1;
      end
      send_rand((i == 299) || ($urandom % 5 == 0));
    end
    bp_mode = 0;
    drain();
    check("rand_sat_cnt", 64'(sat_cnt), 64'(sat_exp));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not complete, %0d tests run", tests);
    $fatal(1, "timeout");
  end

endmodule
